// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - hazard detection and forwarding control for the pipelined MIPS core
module hazard_scoreboard #(
    parameter int REG_AW    = 5,
    parameter int FWD_DEPTH = 2,
    parameter int MUL_LAT   = 4,
    parameter int SEL_W     = $clog2(FWD_DEPTH + 1)
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              IssueValid,
    input  logic [1:0]        IssueClass,
    input  logic [REG_AW-1:0] IssueRs,
    input  logic [REG_AW-1:0] IssueRt,
    input  logic              IssueUsesRs,
    input  logic              IssueUsesRt,
    input  logic [REG_AW-1:0] IssueDest,
    input  logic              IssueWrites,
    input  logic              Flush,
    output logic              Stall,
    output logic              Issued,
    output logic              MultiBusy,
    output logic [SEL_W-1:0]  FwdSelA,
    output logic [SEL_W-1:0]  FwdSelB,
    output logic [SEL_W-1:0]  BrFwdA,
    output logic [SEL_W-1:0]  BrFwdB
);

    localparam int CNT_W = $clog2(MUL_LAT) + 1;

    localparam logic [1:0] CLS_ALU    = 2'd0;
    localparam logic [1:0] CLS_LOAD   = 2'd1;
    localparam logic [1:0] CLS_MULTI  = 2'd2;
    localparam logic [1:0] CLS_BRANCH = 2'd3;

    logic              e_valid;
    logic [1:0]        e_class;
    logic [REG_AW-1:0] e_dest;
    logic              e_writes;

    logic [FWD_DEPTH:1] s_valid;
    logic [FWD_DEPTH:1] s_writes;
    logic [1:0]         s_class [1:FWD_DEPTH];
    logic [REG_AW-1:0]  s_dest  [1:FWD_DEPTH];

    logic [CNT_W-1:0] multi_cnt;

    function automatic logic hit(input logic v, input logic w,
                                 input logic [REG_AW-1:0] d,
                                 input logic [REG_AW-1:0] r,
                                 input logic used);
        return v & w & used & (r != '0) & (d == r);
    endfunction

    function automatic int ready_stage(input logic [1:0] cls);
        return (cls == CLS_LOAD) ? 2 : 1;
    endfunction

    logic               e_hit_a, e_hit_b;
    logic [FWD_DEPTH:1] s_hit_a, s_hit_b;
    logic               busy_raw, is_branch, load_use, br_haz, stall_raw;
    logic [SEL_W-1:0]   fwd_next_a, fwd_next_b, br_a, br_b;

    always_comb begin
        e_hit_a = hit(e_valid, e_writes, e_dest, IssueRs, IssueUsesRs);
        e_hit_b = hit(e_valid, e_writes, e_dest, IssueRt, IssueUsesRt);
        for (int k = 1; k <= FWD_DEPTH; k++) begin
            s_hit_a[k] = hit(s_valid[k], s_writes[k], s_dest[k], IssueRs, IssueUsesRs);
            s_hit_b[k] = hit(s_valid[k], s_writes[k], s_dest[k], IssueRt, IssueUsesRt);
        end
    end

    // A MULTI in EX counts down to zero; its final EX cycle is not busy.
    assign busy_raw  = (multi_cnt != '0);
    assign is_branch = (IssueClass == CLS_BRANCH);
    assign load_use  = (e_class == CLS_LOAD) & (e_hit_a | e_hit_b);
    assign br_haz    = e_hit_a | e_hit_b |
                       ((s_class[1] == CLS_LOAD) & (s_hit_a[1] | s_hit_b[1]));
    assign stall_raw = busy_raw | (is_branch ? br_haz : load_use);

    assign MultiBusy = ~Rst & busy_raw;
    assign Stall     = ~Rst & IssueValid & ~Flush & stall_raw;
    assign Issued    = ~Rst & IssueValid & ~Flush & ~stall_raw;

    // Scan oldest to youngest so the youngest matching producer wins.
    always_comb begin
        fwd_next_a = '0;
        fwd_next_b = '0;
        br_a       = '0;
        br_b       = '0;
        for (int k = FWD_DEPTH; k >= 1; k--) begin
            if (s_hit_a[k]) fwd_next_a = (k + 1 <= FWD_DEPTH) ? SEL_W'(k + 1) : '0;
            if (s_hit_b[k]) fwd_next_b = (k + 1 <= FWD_DEPTH) ? SEL_W'(k + 1) : '0;
            if (s_hit_a[k] && k >= ready_stage(s_class[k])) br_a = SEL_W'(k);
            if (s_hit_b[k] && k >= ready_stage(s_class[k])) br_b = SEL_W'(k);
        end
        if (e_hit_a) fwd_next_a = SEL_W'(1);
        if (e_hit_b) fwd_next_b = SEL_W'(1);
    end

    assign BrFwdA = Rst ? '0 : br_a;
    assign BrFwdB = Rst ? '0 : br_b;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            e_valid   <= 1'b0;
            e_class   <= CLS_ALU;
            e_dest    <= '0;
            e_writes  <= 1'b0;
            s_valid   <= '0;
            s_writes  <= '0;
            for (int k = 1; k <= FWD_DEPTH; k++) begin
                s_class[k] <= CLS_ALU;
                s_dest[k]  <= '0;
            end
            multi_cnt <= '0;
            FwdSelA   <= '0;
            FwdSelB   <= '0;
        end else begin
            for (int k = FWD_DEPTH; k >= 2; k--) begin
                s_valid[k]  <= s_valid[k-1];
                s_writes[k] <= s_writes[k-1];
                s_class[k]  <= s_class[k-1];
                s_dest[k]   <= s_dest[k-1];
            end
            if (busy_raw) begin
                s_valid[1] <= 1'b0;
                multi_cnt  <= multi_cnt - CNT_W'(1);
            end else begin
                s_valid[1]  <= e_valid;
                s_writes[1] <= e_writes;
                s_class[1]  <= e_class;
                s_dest[1]   <= e_dest;
                e_valid     <= Issued;
                e_class     <= IssueClass;
                e_dest      <= IssueDest;
                e_writes    <= IssueWrites;
                multi_cnt   <= (Issued && IssueClass == CLS_MULTI) ? CNT_W'(MUL_LAT - 1) : '0;
                FwdSelA     <= Issued ? fwd_next_a : '0;
                FwdSelB     <= Issued ? fwd_next_b : '0;
            end
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed checks of stall, issue and forwarding selects
module tb_hazard_scoreboard;

    localparam int REG_AW    = 5;
    localparam int FWD_DEPTH = 2;
    localparam int MUL_LAT   = 4;
    localparam int SEL_W     = $clog2(FWD_DEPTH + 1);

    localparam logic [1:0] ALU = 2'd0, LOAD = 2'd1, MULTI = 2'd2, BR = 2'd3;

    logic              Clk = 1'b0;
    logic              Rst;
    logic              IssueValid;
    logic [1:0]        IssueClass;
    logic [REG_AW-1:0] IssueRs, IssueRt, IssueDest;
    logic              IssueUsesRs, IssueUsesRt, IssueWrites;
    logic              Flush;
    logic              Stall, Issued, MultiBusy;
    logic [SEL_W-1:0]  FwdSelA, FwdSelB, BrFwdA, BrFwdB;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    hazard_scoreboard #(
        .REG_AW(REG_AW), .FWD_DEPTH(FWD_DEPTH), .MUL_LAT(MUL_LAT), .SEL_W(SEL_W)
    ) dut (
        .Clk(Clk), .Rst(Rst),
        .IssueValid(IssueValid), .IssueClass(IssueClass),
        .IssueRs(IssueRs), .IssueRt(IssueRt),
        .IssueUsesRs(IssueUsesRs), .IssueUsesRt(IssueUsesRt),
        .IssueDest(IssueDest), .IssueWrites(IssueWrites),
        .Flush(Flush),
        .Stall(Stall), .Issued(Issued), .MultiBusy(MultiBusy),
        .FwdSelA(FwdSelA), .FwdSelB(FwdSelB),
        .BrFwdA(BrFwdA), .BrFwdB(BrFwdB)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic v, input logic [1:0] c,
                         input logic [4:0] rs, input logic [4:0] rt,
                         input logic urs, input logic urt,
                         input logic [4:0] d, input logic w);
        IssueValid  = v;
        IssueClass  = c;
        IssueRs     = rs;
        IssueRt     = rt;
        IssueUsesRs = urs;
        IssueUsesRt = urt;
        IssueDest   = d;
        IssueWrites = w;
    endtask

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Rst   = 1'b1;
        Flush = 1'b0;
        issue(1, BR, 5, 5, 1, 1, 0, 0);
        @(negedge Clk);
        check("rst_stall",  Stall, 0);
        check("rst_issued", Issued, 0);
        check("rst_busy",   MultiBusy, 0);
        check("rst_fwda",   FwdSelA, 0);
        check("rst_brfwda", BrFwdA, 0);
        tick;
        tick;
        Rst = 1'b0;

        // ALU producer then back-to-back consumer
        issue(1, ALU, 1, 2, 0, 0, 3, 1);
        @(negedge Clk); check("first_stall", Stall, 0); check("first_issued", Issued, 1);
        tick;
        issue(1, ALU, 3, 3, 1, 1, 10, 1);
        @(negedge Clk); check("b2b_stall", Stall, 0);
        tick;
        issue(1, ALU, 1, 2, 0, 0, 6, 1);
        @(negedge Clk); check("b2b_fwda", FwdSelA, 1); check("b2b_fwdb", FwdSelB, 1);
        tick;
        issue(1, ALU, 0, 0, 0, 0, 11, 1);
        @(negedge Clk); check("nouse_fwda", FwdSelA, 0);
        tick;
        issue(1, ALU, 6, 6, 1, 1, 12, 1);
        @(negedge Clk); check("gap_stall", Stall, 0);
        tick;
        issue(0, ALU, 0, 0, 0, 0, 0, 0);
        @(negedge Clk); check("gap_fwda", FwdSelA, 2); check("gap_fwdb", FwdSelB, 2);
        tick;

        // load-use
        issue(1, LOAD, 1, 0, 1, 0, 5, 1);
        @(negedge Clk); check("bubble_fwda", FwdSelA, 0); check("ld_issued", Issued, 1);
        tick;
        issue(1, ALU, 5, 0, 1, 0, 13, 1);
        @(negedge Clk); check("lu_stall", Stall, 1); check("lu_issued", Issued, 0);
        tick;
        @(negedge Clk); check("lu_stall2", Stall, 0); check("lu_issued2", Issued, 1);
        tick;
        issue(1, LOAD, 0, 0, 0, 0, 7, 1);
        @(negedge Clk); check("lu_fwda", FwdSelA, 2);
        tick;
        issue(0, ALU, 0, 0, 0, 0, 0, 0);
        tick;
        tick;
        issue(1, ALU, 7, 0, 1, 0, 14, 1);
        @(negedge Clk); check("ld2b_stall", Stall, 0);
        tick;

        // load then branch, ALU then branch
        issue(1, LOAD, 0, 0, 0, 0, 5, 1);
        @(negedge Clk); check("ld2b_fwda", FwdSelA, 0); check("ldb_issued", Issued, 1);
        tick;
        issue(1, BR, 5, 0, 1, 0, 0, 0);
        @(negedge Clk); check("ldbr_stall1", Stall, 1);
        tick;
        @(negedge Clk); check("ldbr_stall2", Stall, 1); check("ldbr_br_early", BrFwdA, 0);
        tick;
        @(negedge Clk); check("ldbr_stall3", Stall, 0); check("ldbr_brfwda", BrFwdA, 2);
        check("ldbr_issued", Issued, 1);
        tick;
        issue(1, ALU, 0, 0, 0, 0, 5, 1);
        tick;
        issue(1, BR, 0, 5, 0, 1, 0, 0);
        @(negedge Clk); check("alubr_stall1", Stall, 1); check("alubr_br_early", BrFwdB, 0);
        tick;
        @(negedge Clk); check("alubr_stall2", Stall, 0); check("alubr_brfwdb", BrFwdB, 1);
        tick;

        // MULTI then dependent ALU
        issue(1, MULTI, 0, 0, 0, 0, 8, 1);
        @(negedge Clk); check("mul_busy0", MultiBusy, 0); check("mul_issued", Issued, 1);
        tick;
        issue(1, ALU, 8, 0, 1, 0, 15, 1);
        for (int i = 0; i < MUL_LAT - 1; i++) begin
            @(negedge Clk); check("mul_busy", MultiBusy, 1); check("mul_stall", Stall, 1);
            tick;
        end
        @(negedge Clk); check("mul_last_busy", MultiBusy, 0); check("mul_last_stall", Stall, 0);
        check("mul_dep_issued", Issued, 1);
        tick;
        issue(1, MULTI, 0, 0, 0, 0, 9, 1);
        @(negedge Clk); check("mul_fwda", FwdSelA, 1);
        tick;

        // reset in the middle of a MULTI
        issue(1, ALU, 9, 0, 1, 0, 16, 1);
        @(negedge Clk); check("mul2_busy", MultiBusy, 1); check("mul2_stall", Stall, 1);
        Rst = 1'b1;
        #1;
        check("rstmid_busy", MultiBusy, 0); check("rstmid_stall", Stall, 0);
        check("rstmid_issued", Issued, 0);
        tick;
        Rst = 1'b0;
        @(negedge Clk); check("postrst_busy", MultiBusy, 0); check("postrst_stall", Stall, 0);
        check("postrst_issued", Issued, 1);
        tick;

        // flush over a load-use hazard
        issue(1, LOAD, 0, 0, 0, 0, 5, 1);
        tick;
        issue(1, ALU, 5, 0, 1, 0, 17, 1);
        Flush = 1'b1;
        @(negedge Clk); check("flush_stall", Stall, 0); check("flush_issued", Issued, 0);
        tick;
        Flush = 1'b0;
        issue(1, BR, 17, 0, 1, 0, 0, 0);
        @(negedge Clk); check("flush_bubble_stall", Stall, 0); check("flush_br_issued", Issued, 1);
        tick;

        // register 0 never hazards
        issue(1, LOAD, 0, 0, 0, 0, 0, 1);
        tick;
        issue(1, ALU, 0, 0, 1, 1, 18, 1);
        @(negedge Clk); check("r0_stall", Stall, 0); check("r0_issued", Issued, 1);
        tick;
        issue(1, ALU, 0, 0, 0, 0, 4, 1);
        @(negedge Clk); check("r0_fwda", FwdSelA, 0);
        tick;

        // youngest producer wins; oldest stage gives register file
        tick;
        issue(1, ALU, 4, 0, 1, 0, 19, 1);
        tick;
        issue(1, ALU, 19, 0, 1, 0, 20, 1);
        @(negedge Clk); check("young_fwda", FwdSelA, 1);
        tick;
        issue(1, ALU, 4, 0, 1, 0, 21, 1);
        @(negedge Clk); check("e_fwda", FwdSelA, 1);
        tick;
        issue(0, ALU, 0, 0, 0, 0, 0, 0);
        @(negedge Clk); check("deep_fwda", FwdSelA, 0);
        tick;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
